// File: rtl/gpio_out_arbiter.sv
// Round-robin arbiter that serialises masked set/clear updates onto one GPIO output/enable pair.
// Each accepted update can hold the bus for a dwell time. Define GPIO_ARB_LOCK_EN to build requester ownership locks.
module gpio_out_arbiter #(
  parameter int NumReq = 4,
  parameter int Width  = 32,
  parameter int HoldW  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_valid_i,
  output logic [NumReq-1:0]         req_ready_o,
  input  logic [NumReq*Width-1:0]   req_mask_i,
  input  logic [NumReq*Width-1:0]   req_data_i,
  input  logic [NumReq*Width-1:0]   req_oe_i,
  input  logic [NumReq*HoldW-1:0]   req_hold_i,
  input  logic [NumReq-1:0]         req_lock_i,
  output logic [Width-1:0]          gpio_o,
  output logic [Width-1:0]          gpio_en_o,
  output logic                      busy_o,
  output logic [$clog2(NumReq)-1:0] grant_id_o
);

  localparam int IdW = $clog2(NumReq);
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [HoldW-1:0] cnt_q, cnt_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [IdW-1:0]   gid_q, gid_d;
  logic [Width-1:0] gpio_q, gpio_d;
  logic [Width-1:0] en_q, en_d;

  logic             gnt_found;
  logic [IdW-1:0]   gnt_idx;
  logic [IdW-1:0]   gnt_next;
  int               cand;
  logic [NumReq-1:0] ready;
  logic             xfer;

  logic [Width-1:0] sel_mask, sel_data, sel_oe;
  logic [HoldW-1:0] sel_hold;
  logic             sel_lock;

`ifdef GPIO_ARB_LOCK_EN
  logic             lock_q, lock_d;
  logic [IdW-1:0]   owner_q, owner_d;
`else
  logic             unused_lock;
  assign unused_lock = ^req_lock_i;
`endif

  // Requester selection: first valid at or after the pointer, or only the lock owner while locked
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NumReq; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdW'(cand);
      end
    end
`ifdef GPIO_ARB_LOCK_EN
    if (lock_q) begin
      gnt_found = req_valid_i[owner_q];
      gnt_idx   = owner_q;
    end
`endif
  end

  always_comb begin
    sel_mask = '0;
    sel_data = '0;
    sel_oe   = '0;
    sel_hold = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt_idx == IdW'(i)) begin
        sel_mask = req_mask_i[i*Width +: Width];
        sel_data = req_data_i[i*Width +: Width];
        sel_oe   = req_oe_i[i*Width +: Width];
        sel_hold = req_hold_i[i*HoldW +: HoldW];
        sel_lock = req_lock_i[i];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (!rst_i && state_q == StIdle && gnt_found) ready[gnt_idx] = 1'b1;
  end

  assign xfer     = |ready;
  assign gnt_next = (gnt_idx == IdW'(NumReq - 1)) ? '0 : gnt_idx + IdW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    gpio_d  = gpio_q;
    en_d    = en_q;
`ifdef GPIO_ARB_LOCK_EN
    lock_d  = lock_q;
    owner_d = owner_q;
`endif
    case (state_q)
      StIdle: begin
        if (xfer) begin
          gpio_d = (sel_mask & sel_data) | (~sel_mask & gpio_q);
          en_d   = (sel_mask & sel_oe) | (~sel_mask & en_q);
          gid_d  = gnt_idx;
          ptr_d  = gnt_next;
`ifdef GPIO_ARB_LOCK_EN
          lock_d  = sel_lock;
          owner_d = gnt_idx;
`endif
          if (sel_hold != '0) begin
            state_d = StHold;
            cnt_d   = sel_hold;
          end
        end
      end
      StHold: begin
        // Leaving on a count of 1 makes the dwell last exactly the requested number of cycles
        cnt_d = cnt_q - HoldW'(1);
        if (cnt_q == HoldW'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      gpio_q  <= '0;
      en_q    <= '0;
`ifdef GPIO_ARB_LOCK_EN
      lock_q  <= 1'b0;
      owner_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      gpio_q  <= gpio_d;
      en_q    <= en_d;
`ifdef GPIO_ARB_LOCK_EN
      lock_q  <= lock_d;
      owner_q <= owner_d;
`endif
    end
  end

  assign req_ready_o = ready;
  assign gpio_o      = gpio_q;
  assign gpio_en_o   = en_q;
  assign grant_id_o  = gid_q;
`ifdef GPIO_ARB_LOCK_EN
  assign busy_o      = (state_q != StIdle) || lock_q;
`else
  assign busy_o      = (state_q != StIdle);
`endif

endmodule

// File: tb/tb_gpio_out_arbiter.sv
// Directed bench for gpio_out_arbiter: reset, round-robin order, dwell timing, masked merge,
// reset during hold, and lock ownership (or lock ignored in the default build).
module tb_gpio_out_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_mask;
  logic [127:0] req_data;
  logic [127:0] req_oe;
  logic [31:0]  req_hold;
  logic [3:0]   req_lock;
  logic [31:0]  gpio;
  logic [31:0]  gpio_en;
  logic         busy;
  logic [1:0]   grant_id;

  int checks   = 0;
  int failures = 0;

  gpio_out_arbiter #(.NumReq(4), .Width(32), .HoldW(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_mask_i  (req_mask),
    .req_data_i  (req_data),
    .req_oe_i    (req_oe),
    .req_hold_i  (req_hold),
    .req_lock_i  (req_lock),
    .gpio_o      (gpio),
    .gpio_en_o   (gpio_en),
    .busy_o      (busy),
    .grant_id_o  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] m, input logic [31:0] d,
                         input logic [31:0] o, input logic [7:0] h, input logic l);
    req_valid[i]          = v;
    req_mask[i*32 +: 32]  = m;
    req_data[i*32 +: 32]  = d;
    req_oe[i*32 +: 32]    = o;
    req_hold[i*8 +: 8]    = h;
    req_lock[i]           = l;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_mask  = '0;
    req_data  = '0;
    req_oe    = '0;
    req_hold  = '0;
    req_lock  = '0;
    repeat (2) @(negedge clk);
    check("rst_gpio", gpio, 32'h0);
    check("rst_en", gpio_en, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_gid", {30'b0, grant_id}, 32'h0);
    check("rst_ready", {28'b0, req_ready}, 32'h0);
    rst = 1'b0;

    // Single update from req0
    set_req(0, 1'b1, 32'hFF, 32'hA5, 32'hFF, 8'd0, 1'b0);
    #1 check("t1_ready", {28'b0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("t1_gpio", gpio, 32'hA5);
    check("t1_en", gpio_en, 32'hFF);
    check("t1_gid", {30'b0, grant_id}, 32'h0);

    // Fresh reset so round-robin starts at 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'h0, 32'h0, 32'h0, 8'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1 check("t2_ready", {28'b0, req_ready}, 32'(1 << (k % 4)));
      @(negedge clk);
      check("t2_gid", {30'b0, grant_id}, 32'(k % 4));
    end
    req_valid = '0;

    // req1 with hold=3, req2 waiting; pointer is at 1
    set_req(1, 1'b1, 32'hF0, 32'h50, 32'hF0, 8'd3, 1'b0);
    set_req(2, 1'b1, 32'h0, 32'h0, 32'h0, 8'd0, 1'b0);
    #1 check("t3_ready1", {28'b0, req_ready}, 32'h2);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("t3_gpio", gpio, 32'h50);
    check("t3_en", gpio_en, 32'hF0);
    for (int j = 0; j < 3; j++) begin
      check("t3_busy_hold", {31'b0, busy}, 32'h1);
      check("t3_ready_hold", {28'b0, req_ready}, 32'h0);
      @(negedge clk);
    end
    check("t3_busy_done", {31'b0, busy}, 32'h0);
    check("t3_ready2", {28'b0, req_ready}, 32'h4);
    @(negedge clk);
    check("t3_gid", {30'b0, grant_id}, 32'h2);
    req_valid[2] = 1'b0;

    // Masked merge; pointer is at 3
    set_req(3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0, 8'd0, 1'b0);
    @(negedge clk);
    check("t4_full", gpio, 32'hFFFF_0000);
    req_valid[3] = 1'b0;
    set_req(0, 1'b1, 32'h0001_0001, 32'h0000_0001, 32'h0001_0001, 8'd0, 1'b0);
    #1 check("t4_ready0", {28'b0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("t4_merge", gpio, 32'hFFFE_0001);
    check("t4_en", gpio_en, 32'h0001_0001);

    // Reset in the middle of a 200-cycle hold; pointer is at 1
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 8'd200, 1'b0);
    #1 check("t5_ready1", {28'b0, req_ready}, 32'h2);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("t5_busy", {31'b0, busy}, 32'h1);
    check("t5_gpio", gpio, 32'h1234_5678);
    repeat (5) @(negedge clk);
    set_req(0, 1'b1, 32'hFF, 32'h3C, 32'hFF, 8'd0, 1'b0);
    #1 check("t5_wait", {28'b0, req_ready}, 32'h0);
    rst = 1'b1;
    #1;
    check("t5_rst_gpio", gpio, 32'h0);
    check("t5_rst_en", gpio_en, 32'h0);
    check("t5_rst_busy", {31'b0, busy}, 32'h0);
    check("t5_rst_gid", {30'b0, grant_id}, 32'h0);
    check("t5_rst_ready", {28'b0, req_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("t5_post_ready", {28'b0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("t5_post_gpio", gpio, 32'h3C);
    check("t5_post_gid", {30'b0, grant_id}, 32'h0);

    // Lock behaviour; pointer is at 1, req0/req3 compete with req2
    set_req(0, 1'b1, 32'h0, 32'h0, 32'h0, 8'd0, 1'b0);
    set_req(3, 1'b1, 32'h0, 32'h0, 32'h0, 8'd0, 1'b0);
    set_req(2, 1'b1, 32'hFF, 32'h11, 32'hFF, 8'd0, 1'b1);
    #1 check("t6_ready2", {28'b0, req_ready}, 32'h4);
    @(negedge clk);
    check("t6_gid", {30'b0, grant_id}, 32'h2);
    check("t6_gpio", gpio, 32'h11);
`ifdef GPIO_ARB_LOCK_EN
    check("t6_busy_lock", {31'b0, busy}, 32'h1);
    for (int j = 0; j < 3; j++) begin
      req_data[2*32 +: 32] = 32'h20 + 32'(j);
      #1 check("t6_ready_locked", {28'b0, req_ready}, 32'h4);
      @(negedge clk);
      check("t6_gpio_locked", gpio, 32'h20 + 32'(j));
      check("t6_busy_locked", {31'b0, busy}, 32'h1);
    end
    req_lock[2] = 1'b0;
    req_data[2*32 +: 32] = 32'h77;
    #1 check("t6_ready_release", {28'b0, req_ready}, 32'h4);
    @(negedge clk);
    check("t6_gpio_release", gpio, 32'h77);
    check("t6_busy_release", {31'b0, busy}, 32'h0);
    req_valid[2] = 1'b0;
    #1 check("t6_ready3", {28'b0, req_ready}, 32'h8);
    @(negedge clk);
    check("t6_gid3", {30'b0, grant_id}, 32'h3);
`else
    check("t6_busy_nolock", {31'b0, busy}, 32'h0);
    #1 check("t6_ready3_nolock", {28'b0, req_ready}, 32'h8);
    @(negedge clk);
    check("t6_gid3_nolock", {30'b0, grant_id}, 32'h3);
`endif
    req_valid = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_out_arbiter.md
# gpio_out_arbiter

Shares one 32-bit GPIO output/output-enable register pair between several hardware requesters. Each requester issues masked set/clear updates over a valid/ready handshake. The block serialises them with round-robin arbitration and enforces a per-update hold (dwell) time, so pulse widths are deterministic. It sits between on-chip masters (timers, protocol engines) and the GPIO pad signals, in place of software-driven masked writes.

## Interface
- `NumReq`, 4: number of requesters, 2..8.
- `Width`, 32: GPIO width.
- `HoldW`, 8: width of the hold-cycle field.
- `clk_i`  in  1: clock; single clock domain.
- `rst_i`  in  1: asynchronous, active-high reset.
- `req_valid_i`  in  NumReq: request valid per requester.
- `req_ready_o`  out  NumReq: request accepted (one-hot or zero).
- `req_mask_i`  in  NumReq×Width: bits to update.
- `req_data_i`  in  NumReq×Width: new output values for masked bits.
- `req_oe_i`  in  NumReq×Width: new output-enable values for masked bits.
- `req_hold_i`  in  NumReq×HoldW: cycles to hold the bus after this update.
- `req_lock_i`  in  NumReq: keep ownership after this update (macro-gated).
- `gpio_o`  out  Width: output values.
- `gpio_en_o`  out  Width: output enables.
- `busy_o`  out  1: FSM not in IDLE, or lock held.
- `grant_id_o`  out  $clog2(NumReq): index of the last accepted requester.

## Operation
- Reset values: `gpio_o`=0, `gpio_en_o`=0, `busy_o`=0, `grant_id_o`=0, `req_ready_o`=0. Round-robin pointer resets to 0. FSM resets to IDLE. Lock is cleared.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - Grant the first valid requester at or after the pointer, searching upward and wrapping mod NumReq.
  - `req_ready_o[g]`=1 combinationally in the same cycle. A transfer occurs when valid and ready are both high.
  - On transfer:
    - `gpio_o` ← (mask & data) | (~mask & `gpio_o`).
    - `gpio_en_o` ← (mask & oe) | (~mask & `gpio_en_o`).
    - `grant_id_o` ← g; pointer ← (g+1) mod NumReq.
  - If hold = 0, stay in IDLE. Otherwise go to HOLD with the counter loaded with hold.
- HOLD:
  - `req_ready_o`=0 for all requesters.
  - The counter decrements each cycle; when the counter is 1, return to IDLE.
  - HOLD therefore lasts exactly hold cycles.
- Requesters must keep `req_valid_i` and their payload stable until ready. The arbiter never grants two requesters in one cycle.
- Mask = 0 is a legal no-op update and still consumes hold time.
- Hold = 2^HoldW−1 is the maximum; the counter does not wrap.
- Reset asserted mid-HOLD or mid-transfer returns all state to reset values immediately. A transfer in flight at that point is lost.

## Timing
- Accept at edge k → `gpio_o`/`gpio_en_o` show the new value from cycle k+1 (1-cycle latency, registered outputs).
- Hold = 0: the next grant is possible in cycle k+1, for back-to-back updates at one per cycle.
- Hold = h > 0: the next grant is possible in cycle k+1+h.
- A request arriving during HOLD waits, without loss, until IDLE.
- Worst-case wait for a valid requester with no locks: (NumReq−1) × (1+max hold) cycles.

## Configuration
- `GPIO_ARB_LOCK_EN` defined:
  - A transfer with `req_lock_i[g]`=1 sets lock owner = g.
  - While locked, only g can be granted; the pointer is ignored.
  - A transfer from g with lock=0 releases the lock; normal round-robin resumes from g+1.
  - `busy_o`=1 while the lock is held.
- `GPIO_ARB_LOCK_EN` undefined: `req_lock_i` is ignored, no lock state is built, and arbitration is pure round-robin.

## Test plan
- Reset, then req0 valid with mask=0xFF, data=0xA5, oe=0xFF, hold=0: ready0 in the same cycle; next cycle `gpio_o`=0xA5, `gpio_en_o`=0xFF, `grant_id_o`=0.
- All four requesters valid continuously, hold=0: grants in order 0,1,2,3,0, one per cycle.
- req1 hold=3, req2 valid throughout: req2 is granted exactly 4 cycles after req1's accept; `busy_o`=1 for 3 cycles.
- Masked merge: `gpio_o`=0xFFFF_0000, then mask=0x0001_0001, data=0x0000_0001 gives 0xFFFE_0001.
- Assert `rst_i` during HOLD with hold=200: outputs read 0 next cycle, FSM is in IDLE, and req0 is grantable right after reset deasserts.
- With `GPIO_ARB_LOCK_EN`: req2 lock=1 while req0/req3 are valid; three further req2 transfers are granted. req2 lock=0 releases, and req3 is granted next.
